// File: rtl/jtframe_ba_arbiter_pkg.sv
// jtframe_ba_arbiter_pkg
// Shared types and constants for the SDRAM bank-port arbiter.
//   state_t  : arbiter FSM states (IDLE, REQ, WAIT)
//   idx_t    : client index type (up to 4 clients)
//   sum_t    : one bit wider than idx_t, used for modulo-CN index arithmetic
//   WDOG_MAX : saturation value of the optional transaction watchdog
package jtframe_ba_arbiter_pkg;

  localparam int OW    = 2;   // client index width
  localparam int MAXCN = 4;   // largest supported client count

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef logic [OW-1:0] idx_t;
  typedef logic [OW:0]   sum_t;

  localparam logic [15:0] WDOG_MAX = 16'hFFFF;

  // Index that follows idx in a ring of cn clients.
  function automatic idx_t next_index(input idx_t idx, input int cn);
    if (int'(idx) >= cn - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/jtframe_ba_rrpick.sv
// jtframe_ba_rrpick
// Combinational round-robin selector.
// Ports:
//   pending [CN-1:0] : request vector, one bit per client
//   start   [1:0]    : first index to consider; search wraps modulo CN
//   valid            : at least one client is pending
//   winner  [1:0]    : first pending client found from start onwards
module jtframe_ba_rrpick
  import jtframe_ba_arbiter_pkg::*;
#(
  parameter int CN = 4
) (
  input  logic [CN-1:0] pending,
  input  idx_t          start,
  output logic          valid,
  output idx_t          winner
);

  logic [MAXCN-1:0] pend_pad;
  idx_t             cand [CN];
  logic [CN-1:0]    hit;

  assign pend_pad = MAXCN'(pending);

  // cand[k] is the client visited k steps after start.
  genvar gi;
  generate
    for (gi = 0; gi < CN; gi++) begin : g_rot
      sum_t sum;
      assign sum      = {1'b0, start} + sum_t'(gi);
      assign cand[gi] = (sum >= sum_t'(CN)) ? idx_t'(sum - sum_t'(CN)) : idx_t'(sum);
      assign hit[gi]  = pend_pad[cand[gi]];
    end
  endgenerate

  // Scan from the far end so the candidate nearest to start is assigned last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = CN - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid  = 1'b1;
        winner = cand[k];
      end
    end
  end

endmodule

// File: rtl/jtframe_ba_arbiter.sv
// jtframe_ba_arbiter
// Round-robin arbiter sharing one jtframe_sdram64 bank port between CN
// clients. Exactly one transaction is outstanding at a time. Read data is
// not muxed: clients sample the controller dout on their own dok/rdy.
// Optional build macro: JTFRAME_BAARB_WDOG_EN adds a transaction watchdog
// and the sticky wdog_err output.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cl_addr/rd/wr/din/din_m : client requests, client i in slice i
//   cl_ack/dok/rdy      : strobes forwarded to the owning client only
//   ba_addr/rd/wr/din/din_m : registered request towards the controller
//   ba_ack/dok/rdy      : controller strobes
//   owner               : current or last granted client
//   wdog_err            : (macro only) transaction took WDOG_MAX cycles
//   busy                : high while in REQ or WAIT
module jtframe_ba_arbiter
  import jtframe_ba_arbiter_pkg::*;
#(
  parameter int CN = 4,
  parameter int AW = 22,
  parameter int RW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CN*AW-1:0] cl_addr,
  input  logic [CN-1:0]    cl_rd,
  input  logic [CN-1:0]    cl_wr,
  input  logic [CN*16-1:0] cl_din,
  input  logic [CN*2-1:0]  cl_din_m,
  output logic [CN-1:0]    cl_ack,
  output logic [CN-1:0]    cl_dok,
  output logic [CN-1:0]    cl_rdy,
  output logic [AW-1:0]    ba_addr,
  output logic             ba_rd,
  output logic             ba_wr,
  output logic [15:0]      ba_din,
  output logic [1:0]       ba_din_m,
  input  logic             ba_ack,
  input  logic             ba_dok,
  input  logic             ba_rdy,
  output logic [1:0]       owner,
`ifdef JTFRAME_BAARB_WDOG_EN
  output logic             wdog_err,
`endif
  output logic             busy
);

  state_t        state_reg;
  idx_t          owner_reg;
  logic [AW-1:0] ba_addr_reg;
  logic          ba_rd_reg;
  logic          ba_wr_reg;
  logic [15:0]   ba_din_reg;
  logic [1:0]    ba_din_m_reg;

  // Unpacked views of the client buses
  logic [AW-1:0] addr_arr [CN];
  logic [15:0]   din_arr  [CN];
  logic [1:0]    mask_arr [CN];

  genvar gi;
  generate
    for (gi = 0; gi < CN; gi++) begin : g_unpack
      assign addr_arr[gi] = cl_addr[gi*AW +: AW];
      assign din_arr[gi]  = cl_din[gi*16 +: 16];
      assign mask_arr[gi] = cl_din_m[gi*2 +: 2];
    end
  endgenerate

  // Round-robin pick, starting one past the last owner
  logic [CN-1:0] pending;
  idx_t          start_idx;
  logic          pick_valid;
  idx_t          pick_idx;

  assign pending   = cl_rd | cl_wr;
  assign start_idx = next_index(owner_reg, CN);

  jtframe_ba_rrpick #(.CN(CN)) u_pick (
    .pending (pending),
    .start   (start_idx),
    .valid   (pick_valid),
    .winner  (pick_idx)
  );

  // Winner's request fields
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_din;
  logic [1:0]    sel_mask;
  logic          sel_wr;
  logic          wr_grant;

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_mask = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < CN; i++) begin
      if (pick_idx == idx_t'(i)) begin
        sel_addr = addr_arr[i];
        sel_din  = din_arr[i];
        sel_mask = mask_arr[i];
        sel_wr   = cl_wr[i];
      end
    end
  end

  // A client raising both rd and wr is treated as a write; read-only
  // builds turn every write into a read.
  assign wr_grant = sel_wr && (RW != 0);

  // Strobe qualification. dok/rdy are also honoured in the ack cycle so a
  // controller that acks and completes in the same cycle is handled.
  logic ack_fwd;
  logic strobe_win;
  logic dok_fwd;
  logic rdy_fwd;

  assign ack_fwd    = (state_reg == REQ) && ba_ack;
  assign strobe_win = (state_reg == WAIT) || ack_fwd;
  assign dok_fwd    = strobe_win && ba_dok;
  assign rdy_fwd    = strobe_win && ba_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ba_addr_reg  <= '0;
      ba_rd_reg    <= 1'b0;
      ba_wr_reg    <= 1'b0;
      ba_din_reg   <= '0;
      ba_din_m_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner_reg    <= pick_idx;
            ba_addr_reg  <= sel_addr;
            ba_din_reg   <= sel_din;
            ba_din_m_reg <= sel_mask;
            ba_wr_reg    <= wr_grant;
            ba_rd_reg    <= ~wr_grant;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (ba_ack) begin
            ba_rd_reg <= 1'b0;
            ba_wr_reg <= 1'b0;
            state_reg <= rdy_fwd ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (rdy_fwd) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-client strobe forwarding: only the owner ever sees a strobe
  generate
    for (gi = 0; gi < CN; gi++) begin : g_fwd
      logic is_owner;
      assign is_owner   = (owner_reg == idx_t'(gi));
      assign cl_ack[gi] = is_owner & ack_fwd;
      assign cl_dok[gi] = is_owner & dok_fwd;
      assign cl_rdy[gi] = is_owner & rdy_fwd;
    end
  endgenerate

`ifdef JTFRAME_BAARB_WDOG_EN
  // Counts cycles spent in REQ/WAIT. The count starts on the first edge
  // after entering REQ, so the flag rises WDOG_MAX cycles after entry.
  // The transaction is not aborted.
  logic [15:0] wdog_cnt_reg;
  logic        wdog_err_reg;
  logic        wdog_run;

  assign wdog_run = (state_reg != IDLE) && !rdy_fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      if (!wdog_run) begin
        wdog_cnt_reg <= '0;
      end else if (wdog_cnt_reg != WDOG_MAX) begin
        wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
      end
      if (wdog_run && (wdog_cnt_reg == WDOG_MAX - 16'd1)) wdog_err_reg <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_reg;
`endif

  assign ba_addr  = ba_addr_reg;
  assign ba_rd    = ba_rd_reg;
  assign ba_wr    = ba_wr_reg;
  assign ba_din   = ba_din_reg;
  assign ba_din_m = ba_din_m_reg;
  assign owner    = owner_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_jtframe_ba_arbiter.sv
// Directed testbench for jtframe_ba_arbiter. A second instance built with
// RW=0 shares all inputs; it follows the same FSM and differs only in how
// writes are presented to the controller.
module tb_jtframe_ba_arbiter;

  localparam int CN = 4;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CN*AW-1:0] cl_addr;
  logic [CN-1:0]    cl_rd, cl_wr;
  logic [CN*16-1:0] cl_din;
  logic [CN*2-1:0]  cl_din_m;
  logic             ba_ack, ba_dok, ba_rdy;

  logic [CN-1:0] cl_ack, cl_dok, cl_rdy;
  logic [AW-1:0] ba_addr;
  logic          ba_rd, ba_wr, busy;
  logic [15:0]   ba_din;
  logic [1:0]    ba_din_m, owner;

  logic [CN-1:0] ro_cl_ack, ro_cl_dok, ro_cl_rdy;
  logic [AW-1:0] ro_ba_addr;
  logic          ro_ba_rd, ro_ba_wr, ro_busy;
  logic [15:0]   ro_ba_din;
  logic [1:0]    ro_ba_din_m, ro_owner;

`ifdef JTFRAME_BAARB_WDOG_EN
  logic wdog_err, ro_wdog_err;
`endif

  int errors = 0;
  int checks = 0;

  jtframe_ba_arbiter #(.CN(CN), .AW(AW), .RW(1)) dut (
    .clk(clk), .rst(rst),
    .cl_addr(cl_addr), .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_din(cl_din), .cl_din_m(cl_din_m),
    .cl_ack(cl_ack), .cl_dok(cl_dok), .cl_rdy(cl_rdy),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m),
    .ba_ack(ba_ack), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .owner(owner),
`ifdef JTFRAME_BAARB_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy(busy)
  );

  jtframe_ba_arbiter #(.CN(CN), .AW(AW), .RW(0)) dut_ro (
    .clk(clk), .rst(rst),
    .cl_addr(cl_addr), .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_din(cl_din), .cl_din_m(cl_din_m),
    .cl_ack(ro_cl_ack), .cl_dok(ro_cl_dok), .cl_rdy(ro_cl_rdy),
    .ba_addr(ro_ba_addr), .ba_rd(ro_ba_rd), .ba_wr(ro_ba_wr), .ba_din(ro_ba_din),
    .ba_din_m(ro_ba_din_m),
    .ba_ack(ba_ack), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .owner(ro_owner),
`ifdef JTFRAME_BAARB_WDOG_EN
    .wdog_err(ro_wdog_err),
`endif
    .busy(ro_busy)
  );

  // Advance one clock; inputs driven after this are stable for the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cl_addr  = '0;
    cl_rd    = '0;
    cl_wr    = '0;
    cl_din   = '0;
    cl_din_m = '0;
    ba_ack   = 1'b0;
    ba_dok   = 1'b0;
    ba_rdy   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL reset_ba_rd: got %b want 0", ba_rd); end
    checks++; if (ba_wr !== 1'b0) begin errors++; $display("FAIL reset_ba_wr: got %b want 0", ba_wr); end
    checks++; if (ba_addr !== 22'h0) begin errors++; $display("FAIL reset_ba_addr: got %h want 0", ba_addr); end
    checks++; if ({ba_din, ba_din_m} !== 18'h0) begin errors++; $display("FAIL reset_ba_din: got %h want 0", {ba_din, ba_din_m}); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({cl_ack, cl_dok, cl_rdy} !== 12'h0) begin errors++; $display("FAIL reset_strobes: got %h want 0", {cl_ack, cl_dok, cl_rdy}); end
    $display("txn reset: done");
  endtask

  task automatic test_single_read();
    cl_addr[2*AW +: AW] = 22'h1234;
    cl_rd = 4'b0100;
    step();  // grant edge
    #1;
    checks++; if (ba_rd !== 1'b1 || ba_wr !== 1'b0) begin errors++; $display("FAIL read_grant_rdwr: got rd=%b wr=%b want rd=1 wr=0", ba_rd, ba_wr); end
    checks++; if (ba_addr !== 22'h1234) begin errors++; $display("FAIL read_addr: got %h want 1234", ba_addr); end
    checks++; if (owner !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL read_owner_busy: got owner=%0d busy=%b want 2 1", owner, busy); end
    step();
    #1;
    checks++; if (ba_rd !== 1'b1 || cl_ack !== 4'b0000) begin errors++; $display("FAIL read_hold: got rd=%b ack=%b want 1 0000", ba_rd, cl_ack); end
    step();
    ba_ack = 1'b1;
    #1;
    checks++; if (cl_ack !== 4'b0100) begin errors++; $display("FAIL read_ack: got %b want 0100", cl_ack); end
    step();
    ba_ack = 1'b0;
    cl_rd  = '0;
    #1;
    checks++; if (ba_rd !== 1'b0 || busy !== 1'b1 || cl_ack !== 4'b0000) begin errors++; $display("FAIL read_wait: got rd=%b busy=%b ack=%b want 0 1 0000", ba_rd, busy, cl_ack); end
    for (int i = 0; i < 5; i++) step();
    ba_dok = 1'b1;
    ba_rdy = 1'b1;
    #1;
    checks++; if (cl_dok !== 4'b0100 || cl_rdy !== 4'b0100) begin errors++; $display("FAIL read_dok_rdy: got dok=%b rdy=%b want 0100 0100", cl_dok, cl_rdy); end
    step();
    ba_dok = 1'b0;
    ba_rdy = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_done_idle: got busy=%b want 0", busy); end
    // Stray controller strobes in IDLE
    ba_dok = 1'b1;
    ba_rdy = 1'b1;
    #1;
    checks++; if (cl_dok !== 4'b0000 || cl_rdy !== 4'b0000) begin errors++; $display("FAIL idle_stray: got dok=%b rdy=%b want 0000 0000", cl_dok, cl_rdy); end
    step();
    ba_dok = 1'b0;
    ba_rdy = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || owner !== 2'd2) begin errors++; $display("FAIL idle_stray_state: got busy=%b owner=%0d want 0 2", busy, owner); end
    $display("txn read: client 2 addr 1234");
  endtask

  task automatic test_write_mask();
    // rd and wr together from client 0: write must win
    cl_addr[0 +: AW] = 22'h3ABCD;
    cl_din[0 +: 16]  = 16'hBEEF;
    cl_din_m[0 +: 2] = 2'b01;
    cl_wr = 4'b0001;
    cl_rd = 4'b0001;
    step();
    #1;
    checks++; if (ba_wr !== 1'b1 || ba_rd !== 1'b0) begin errors++; $display("FAIL write_rdwr: got rd=%b wr=%b want 0 1", ba_rd, ba_wr); end
    checks++; if (ba_din !== 16'hBEEF || ba_din_m !== 2'b01) begin errors++; $display("FAIL write_data: got %h/%b want beef/01", ba_din, ba_din_m); end
    checks++; if (owner !== 2'd0 || ba_addr !== 22'h3ABCD) begin errors++; $display("FAIL write_owner_addr: got %0d/%h want 0/3abcd", owner, ba_addr); end
    checks++; if (ro_ba_rd !== 1'b1 || ro_ba_wr !== 1'b0) begin errors++; $display("FAIL write_ro_rdwr: got rd=%b wr=%b want 1 0", ro_ba_rd, ro_ba_wr); end
    checks++; if (ro_ba_din !== 16'hBEEF) begin errors++; $display("FAIL write_ro_din: got %h want beef", ro_ba_din); end
    ba_ack = 1'b1;
    #1;
    checks++; if (cl_ack !== 4'b0001) begin errors++; $display("FAIL write_ack: got %b want 0001", cl_ack); end
    step();
    ba_ack = 1'b0;
    cl_wr  = '0;
    cl_rd  = '0;
    ba_rdy = 1'b1;
    #1;
    checks++; if (cl_rdy !== 4'b0001) begin errors++; $display("FAIL write_rdy: got %b want 0001", cl_rdy); end
    step();
    ba_rdy = 1'b0;
    $display("txn write: client 0 din beef mask 01");
  endtask

  task automatic test_drop_before_ack();
    // owner 0, search starts at 1
    cl_addr[1*AW +: AW] = 22'h00777;
    cl_rd = 4'b0010;
    step();
    cl_rd = '0;
    step();
    #1;
    checks++; if (ba_rd !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL drop_hold: got rd=%b owner=%0d want 1 1", ba_rd, owner); end
    ba_ack = 1'b1;
    #1;
    checks++; if (cl_ack !== 4'b0010) begin errors++; $display("FAIL drop_ack: got %b want 0010", cl_ack); end
    step();
    ba_ack = 1'b0;
    ba_dok = 1'b1;
    #1;
    checks++; if (cl_dok !== 4'b0010 || cl_rdy !== 4'b0000) begin errors++; $display("FAIL drop_dok: got dok=%b rdy=%b want 0010 0000", cl_dok, cl_rdy); end
    step();
    ba_dok = 1'b0;
    ba_rdy = 1'b1;
    #1;
    checks++; if (cl_rdy !== 4'b0010) begin errors++; $display("FAIL drop_rdy: got %b want 0010", cl_rdy); end
    step();
    ba_rdy = 1'b0;
    $display("txn drop: client 1 completed after dropping request");
  endtask

  task automatic test_coincident();
    // owner 1, search starts at 2; only client 3 pending
    cl_addr[3*AW +: AW] = 22'h2F00F;
    cl_rd = 4'b1000;
    step();
    #1;
    checks++; if (owner !== 2'd3 || ba_rd !== 1'b1) begin errors++; $display("FAIL coin_grant: got owner=%0d rd=%b want 3 1", owner, ba_rd); end
    ba_ack = 1'b1;
    ba_rdy = 1'b1;
    cl_addr[1*AW +: AW] = 22'h00042;
    cl_rd = 4'b1010;
    #1;
    checks++; if (cl_ack !== 4'b1000 || cl_rdy !== 4'b1000) begin errors++; $display("FAIL coin_strobes: got ack=%b rdy=%b want 1000 1000", cl_ack, cl_rdy); end
    step();
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    cl_rd  = 4'b0010;
    #1;
    checks++; if (busy !== 1'b0 || ba_rd !== 1'b0) begin errors++; $display("FAIL coin_idle: got busy=%b rd=%b want 0 0", busy, ba_rd); end
    step();
    #1;
    checks++; if (ba_rd !== 1'b1 || owner !== 2'd1 || ba_addr !== 22'h00042) begin errors++; $display("FAIL coin_next: got rd=%b owner=%0d addr=%h want 1 1 42", ba_rd, owner, ba_addr); end
    ba_ack = 1'b1;
    step();
    ba_ack = 1'b0;
    cl_rd  = '0;
    ba_rdy = 1'b1;
    step();
    ba_rdy = 1'b0;
    $display("txn coincident: client 3 ack+rdy, then client 1");
  endtask

  task automatic test_reset_in_wait();
    // owner 1, search starts at 2
    cl_addr[2*AW +: AW] = 22'h15555;
    cl_rd = 4'b0100;
    step();
    ba_ack = 1'b1;
    step();
    ba_ack = 1'b0;
    cl_rd  = '0;
    step();
    #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL rstw_pre: got busy=%b owner=%0d want 1 2", busy, owner); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || owner !== 2'd0 || ba_rd !== 1'b0 || ba_addr !== 22'h0) begin errors++; $display("FAIL rstw_outputs: got busy=%b owner=%0d rd=%b addr=%h want 0 0 0 0", busy, owner, ba_rd, ba_addr); end
    ba_rdy = 1'b1;
    ba_dok = 1'b1;
    #1;
    checks++; if (cl_rdy !== 4'b0000 || cl_dok !== 4'b0000) begin errors++; $display("FAIL rstw_late_rdy: got rdy=%b dok=%b want 0000 0000", cl_rdy, cl_dok); end
    step();
    ba_rdy = 1'b0;
    ba_dok = 1'b0;
    $display("txn reset_in_wait: client 2 aborted");
  endtask

  task automatic test_round_robin();
    int exp_owner;
    for (int c = 0; c < CN; c++) cl_addr[c*AW +: AW] = 22'h100 + 22'(c);
    cl_rd = 4'b1111;
    exp_owner = 1;  // owner is 0 after reset
    for (int n = 0; n < 8; n++) begin
      step();
      #1;
      checks++; if (ba_rd !== 1'b1 || owner !== 2'(exp_owner)) begin errors++; $display("FAIL rr_grant%0d: got rd=%b owner=%0d want 1 %0d", n, ba_rd, owner, exp_owner); end
      checks++; if (ba_addr !== 22'h100 + 22'(exp_owner)) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", n, ba_addr, 22'h100 + 22'(exp_owner)); end
      ba_ack = 1'b1;
      #1;
      checks++; if (cl_ack !== 4'(1 << exp_owner)) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", n, cl_ack, 4'(1 << exp_owner)); end
      step();
      ba_ack = 1'b0;
      ba_rdy = 1'b1;
      #1;
      checks++; if (cl_rdy !== 4'(1 << exp_owner)) begin errors++; $display("FAIL rr_rdy%0d: got %b want %b", n, cl_rdy, 4'(1 << exp_owner)); end
      step();
      ba_rdy = 1'b0;
      #1;
      checks++; if (ba_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got rd=%b busy=%b want 0 0", n, ba_rd, busy); end
      $display("txn rr: grant %0d to client %0d", n, exp_owner);
      if (n == 7) cl_rd = '0;
      exp_owner = (exp_owner + 1) % CN;
    end
  endtask

`ifdef JTFRAME_BAARB_WDOG_EN
  task automatic test_wdog();
    int cnt;
    cl_addr[2*AW +: AW] = 22'h0DEAD;
    cl_rd = 4'b0100;
    step();  // enters REQ
    cl_rd = '0;
    #1;
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b want 0", wdog_err); end
    cnt = 0;
    while (wdog_err !== 1'b1 && cnt < 70000) begin
      step();
      cnt++;
    end
    checks++; if (cnt != 65535) begin errors++; $display("FAIL wdog_latency: got %0d want 65535", cnt); end
    for (int i = 0; i < 4; i++) step();
    #1;
    checks++; if (wdog_err !== 1'b1 || busy !== 1'b1 || ba_rd !== 1'b1) begin errors++; $display("FAIL wdog_hold: got err=%b busy=%b rd=%b want 1 1 1", wdog_err, busy, ba_rd); end
    ba_ack = 1'b1;
    ba_rdy = 1'b1;
    step();
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    step();
    #1;
    checks++; if (wdog_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdog_sticky: got err=%b busy=%b want 1 0", wdog_err, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_rst: got %b want 0", wdog_err); end
    $display("txn wdog: client 2 stalled %0d cycles", cnt);
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_mask();
    test_drop_before_ack();
    test_coincident();
    test_reset_in_wait();
    test_round_robin();
`ifdef JTFRAME_BAARB_WDOG_EN
    test_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_ba_arbiter.md
Name: jtframe_ba_arbiter

Overview:
- Shares one jtframe_sdram64 bank port (addr/rd/wr/din/din_m with ack/rdy/dok) between CN clients using round-robin scheduling.
- Sits between game-side requesters (ROM fetchers, CPU RAM writer) and one SDRAM controller bank port.
- Only bank 0 of the controller accepts writes; the arbiter forwards writes and keeps exactly one transaction outstanding.
- Read data is not muxed: clients sample the controller's common dout bus on their own dok/rdy.

Parameters:
- CN, 4, number of clients (2..4).
- AW, 22, SDRAM word address width.
- RW, 1, 1 allows writes to pass; 0 forces ba_wr low and treats client wr as rd.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- cl_addr  input  CN*AW  client addresses, client i at [i*AW +: AW].
- cl_rd  input  CN  read requests, held high until the matching cl_ack.
- cl_wr  input  CN  write requests, held high until the matching cl_ack.
- cl_din  input  CN*16  write data.
- cl_din_m  input  CN*2  write byte mask, 1 = keep that byte.
- cl_ack  output  CN  one-cycle pulse to the owner when the controller accepts its request.
- cl_dok  output  CN  data-valid strobe, forwarded to the owner.
- cl_rdy  output  CN  transaction-complete strobe, forwarded to the owner.
- ba_addr  output  AW  to controller.
- ba_rd  output  1  to controller.
- ba_wr  output  1  to controller.
- ba_din  output  16  to controller.
- ba_din_m  output  2  to controller.
- ba_ack  input  1  from controller.
- ba_dok  input  1  from controller.
- ba_rdy  input  1  from controller.
- owner  output  2  index of the current or last granted client.
- busy  output  1  high in REQ and WAIT.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- Reset asserted mid-transaction aborts it immediately. No ack/rdy/dok is forwarded afterwards.
- States: IDLE, REQ, WAIT.
- IDLE:
  - A client is pending when cl_rd[i] or cl_wr[i] is high.
  - Search order starts at owner+1 modulo CN.
  - The first pending client wins. Its addr, din and din_m are latched into ba_addr, ba_din and ba_din_m.
  - Next cycle: ba_wr = cl_wr & RW, ba_rd = the inverse of that. Write wins if a client asserts both rd and wr.
  - owner is updated; state goes to REQ. Grant-to-ba_rd/ba_wr latency is 1 cycle.
- REQ:
  - ba_rd/ba_wr are held until ba_ack.
  - cl_ack[owner] = ba_ack, combinational, same cycle.
  - On ba_ack, ba_rd/ba_wr drop on the next edge and state goes to WAIT, or to IDLE if ba_rdy coincides.
- WAIT:
  - cl_dok[owner] = ba_dok and cl_rdy[owner] = ba_rdy, combinational.
  - On ba_rdy the state goes to IDLE. The earliest next grant is the cycle after ba_rdy, so there is one idle cycle between transactions.
- Non-owners see cl_ack, cl_dok and cl_rdy as 0 at all times.
- Client drops its request before ack: the latched request still runs to completion and the client still receives ack and rdy.
- A ba_dok or ba_rdy arriving in IDLE is ignored.
- Fairness: with all clients requesting continuously, each client gets exactly one grant per CN transactions.
- owner wraps CN-1 -> 0.

Optional Feature:
- Macro: JTFRAME_BAARB_WDOG_EN.
- When defined:
  - A 16-bit counter runs in REQ/WAIT and clears on entry to IDLE.
  - Reaching 16'hFFFF sets a sticky output wdog_err. Only rst clears it.
  - The counter saturates at 16'hFFFF.
  - The FSM keeps waiting; the watchdog does not abort the transaction.
- When undefined: no counter and no wdog_err port.

Decomposition:
- Package jtframe_ba_arbiter_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - WDOG_MAX = 16'hFFFF.
- Sub-module jtframe_ba_rrpick: combinational round-robin selector. Inputs: CN-bit pending vector and start index. Outputs: valid and winner index.
- FSM, latches and strobe forwarding stay in the top module.

Test Plan:
- Single read: client 2 rd at addr 0x1234; ack after 3 cycles, dok+rdy 6 cycles later.
  -> ba_rd high 1 cycle after the request until the ack edge.
  -> cl_ack[2], cl_dok[2] and cl_rdy[2] pulse on those cycles; other clients stay 0.
- Write with mask: client 0 wr, din 0xBEEF, din_m 2'b01.
  -> ba_wr=1, ba_rd=0, ba_din=0xBEEF, ba_din_m=01.
  -> With RW=0: ba_rd=1, ba_wr=0.
- Round-robin: all 4 clients requesting permanently from reset.
  -> Grant order 1,2,3,0,1..., one grant per transaction, one idle cycle between rdy and the next ba_rd.
- Coincident ack+rdy in one cycle.
  -> Both forwarded to the owner in that cycle; FSM goes straight to IDLE; the next grant occurs the following cycle.
- rst asserted during WAIT.
  -> Next cycle all outputs are 0 and state is IDLE; a later ba_rdy is not forwarded; the next grant goes to client 1 first.
- With JTFRAME_BAARB_WDOG_EN, ba_ack never arrives.
  -> wdog_err rises 65535 cycles after entering REQ and stays high until rst.
